// File: rtl/ab_seq_responder.sv
// Target-side responder for the "a ##1 b" protocol: each accepted request yields a
// one-cycle b pulse LAT cycles later, with request/response/miss counters and drop injection.
module ab_seq_responder #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             c,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             inj,
  input  logic             clr,
  output logic             b,
  output logic             busy,
  output logic             armed,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] rsp_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_DISARMED = 1'b0,
    ST_ARMED    = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [LAT-1:0]   pend_q, pend_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             acc;
  logic             suppress;
  logic             armed_c;

  // Saturating counter step; clear wins over increment.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic clr_i);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr_i) begin
      nxt = '0;
    end else if (inc && (cur != CNT_MAX)) begin
      nxt = cur + CNT_W'(1);
    end
    return nxt;
  endfunction

  assign acc      = en & a;
  assign suppress = acc & (state_q == ST_ARMED);

  // Injection FSM: state register.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DISARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Injection FSM: next state. An inj arriving while armed is absorbed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_DISARMED: if (inj) state_d = ST_ARMED;
      ST_ARMED:    if (acc) state_d = ST_DISARMED;
      default:     state_d = ST_DISARMED;
    endcase
  end

  // Injection FSM: output.
  always_comb begin
    armed_c = 1'b0;
    if (state_q == ST_ARMED) armed_c = 1'b1;
  end

  // Response pipeline and counters; the cast drops the bit shifted out of the top.
  always_comb begin
    pend_d     = LAT'({pend_q, acc & ~suppress});
    busy_d     = |pend_d;
    req_cnt_d  = cnt_next(req_cnt_q, acc, clr);
    rsp_cnt_d  = cnt_next(rsp_cnt_q, pend_q[LAT-1], clr);
    miss_cnt_d = cnt_next(miss_cnt_q, suppress, clr);
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      busy_q     <= 1'b0;
      req_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign b        = pend_q[LAT-1];
  assign busy     = busy_q;
  assign armed    = armed_c;
  assign req_cnt  = req_cnt_q;
  assign rsp_cnt  = rsp_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: doc/ab_seq_responder.md
# ab_seq_responder

Target-side responder for the two-signal "a ##1 b" request/response protocol checked by the team's concurrent-assertion benches. Every request `a` sampled high at a rising edge of `c` produces a one-cycle `b` pulse exactly LAT cycles later. The block keeps request, response and miss counters. An injection input deliberately drops one response, so benches can exercise both the pass and fail branches of their protocol assertions against real RTL.

## Interface
- LAT, 1, response latency in clock cycles; legal range 1..8
- CNT_W, 8, width of each event counter
- c  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  request accept enable; when low, `a` is ignored
- a  input  1  request, sampled at the rising edge of `c`
- inj  input  1  one-cycle pulse; arms suppression of the next accepted request's response
- clr  input  1  synchronous clear of all three counters
- b  output  1  response pulse, driven directly from a flop
- busy  output  1  high while any response is in flight
- armed  output  1  injection armed, no request consumed yet
- req_cnt  output  CNT_W  accepted requests, saturating
- rsp_cnt  output  CNT_W  responses driven, saturating
- miss_cnt  output  CNT_W  suppressed responses, saturating

## Operation
- Pipeline: LAT-bit shift register `pend`, shifted on every edge regardless of `en`.
  - pend[0] <= acc & ~armed, where acc = en & a.
  - b = pend[LAT-1].
- Accept: acc = en & a at the rising edge. When `en` is low, a 0 is shifted in. In-flight responses still drain.
- Injection state machine:
  - DISARMED -> ARMED when inj=1.
  - ARMED -> DISARMED on the first edge with acc=1. That request enters the pipeline as 0, and miss_cnt increments.
  - inj while already ARMED: no effect; suppressions do not stack.
  - inj and acc in the same cycle while DISARMED: that request is still answered; ARMED takes effect from the next edge.
  - armed output = state ARMED.
- Counters:
  - req_cnt +1 per acc, including suppressed requests.
  - rsp_cnt +1 per edge with b=1.
  - miss_cnt +1 per suppression.
  - All counters hold at 2^CNT_W-1 and never wrap.
  - clr has priority over increments in the same cycle.
- busy = |pend.
- Back-to-back requests are fully supported: `a` held high for N accepted cycles gives N consecutive `b` cycles.

## Timing
- Reset (rst_n low, asynchronous): pend=0, b=0, busy=0, armed=0, all counters 0. Outputs reach these values immediately on assertion, without waiting for a clock edge.
- Reset release: the first edge with rst_n high may accept a request.
- Reset mid-operation discards all in-flight responses; no `b` pulse appears afterwards for requests taken before reset.
- Latency: `a` sampled at edge k gives b=1 during the cycle after edge k+LAT-1.
  - With LAT=1, b is high for the cycle following the request edge, i.e. a ##1 b.
- req_cnt updates at the accept edge. rsp_cnt updates at the edge that samples b=1, which is one cycle after `b` rises.
- All outputs are registered or pure functions of registers; there is no combinational path from any input to any output.

## Test plan
- LAT=1, clock period 10, inputs changed on the falling edge, en=1. Drive a=0 b-phase, then a=1 for 3 cycles, then a=0, then a=1 for 2 cycles.
  -> b high exactly one cycle after each `a` cycle.
  -> An "a ##1 b" assertion never fails.
  -> req_cnt=5, rsp_cnt=5, miss_cnt=0.
- LAT=3, single `a` pulse at edge 2.
  -> b high only in the cycle after edge 4.
  -> busy high during cycles 3..5.
  -> rsp_cnt=1.
- Injection: pulse inj, then a=1 for 2 cycles.
  -> First request gets no `b`; second gets b one cycle later.
  -> The assertion fails exactly once.
  -> miss_cnt=1, req_cnt=2, armed returns to 0.
  -> A second inj while armed leaves miss_cnt at 1 after one request.
- en=0 with a=1 for 4 cycles.
  -> No new `b`; req_cnt unchanged.
  -> A response issued one cycle before en fell still appears.
- Reset with rst_n low mid-pipeline (LAT=4, two requests in flight).
  -> b, busy and the counters drop to 0 immediately.
  -> No `b` pulse appears after release.
- CNT_W=2, 5 requests.
  -> req_cnt saturates at 3.
  -> clr together with an accept gives req_cnt=0.
